dbus_dmem_resp: RTL and testbench

- Responder end of the LSU data-bus (dbus) protocol: a byte-writable on-chip data scratchpad that services the load and store requests the LSU issues.
- Sits in the data path where the dcache or uncached path would otherwise terminate dbus requests.
- Consumes the lsu2dbus request struct and returns the dbus2lsu struct (ack, r_data).
- Lane steering is split between the two ends:
  - loads: this block returns the full aligned word; the LSU extracts bytes and halfwords itself;
  - stores: this block does byte-lane steering itself, because the LSU drives unshifted rs2 data.

---
 rtl/dbus_dmem_resp_pkg.sv | 69 ++++++
 rtl/dbus_dmem_resp_if.sv | 12 +
 rtl/dbus_sram_bank.sv | 33 +++
 rtl/dbus_dmem_resp.sv | 130 +++++++++++++
 tb/tb_dbus_dmem_resp.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/dbus_dmem_resp_pkg.sv
// Shared dbus request/response types, responder FSM states and store lane helpers.
// The lane helpers are written so dcache store logic can reuse them.
package dbus_dmem_resp_pkg;

    typedef enum logic [1:0] {
        StOpSb = 2'd0,
        StOpSh = 2'd1,
        StOpSw = 2'd2
    } type_st_ops_e;

    typedef struct packed {
        logic [31:0]  addr;
        logic [31:0]  w_data;
        logic         ld_req;
        logic         st_req;
        type_st_ops_e st_ops;
    } type_lsu2dbus_s;

    typedef struct packed {
        logic        ack;
        logic [31:0] r_data;
    } type_dbus2lsu_s;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } type_dbus_resp_state_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } type_st_lane_s;

    // The LSU drives unshifted rs2, so the byte/half is replicated across all lanes.
    function automatic type_st_lane_s build_st_lane(input type_st_ops_e st_ops,
                                                    input logic [1:0]   addr_lo,
                                                    input logic [31:0]  w_data);
        type_st_lane_s lane;
        lane.be   = 4'b0000;
        lane.data = 32'h0;
        case (st_ops)
            StOpSb: begin
                lane.be   = 4'b0001 << addr_lo;
                lane.data = {4{w_data[7:0]}};
            end
            StOpSh: begin
                lane.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane.data = {2{w_data[15:0]}};
            end
            StOpSw: begin
                lane.be   = 4'b1111;
                lane.data = w_data;
            end
            default: ;
        endcase
        return lane;
    endfunction

    function automatic logic st_misaligned(input type_st_ops_e st_ops,
                                           input logic [1:0]   addr_lo);
        case (st_ops)
            StOpSh:  return addr_lo[0];
            StOpSw:  return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_dmem_resp_if.sv
// dbus request/response bundle between the LSU (master) and a dbus responder (slave).
interface dbus_dmem_resp_if;
    import dbus_dmem_resp_pkg::*;

    type_lsu2dbus_s lsu2dbus;
    type_dbus2lsu_s dbus2lsu;
    logic           addr_err;

    modport master (output lsu2dbus, input dbus2lsu, input addr_err);
    modport slave (input lsu2dbus, output dbus2lsu, output addr_err);

endinterface

// File: rtl/dbus_sram_bank.sv
// Single-port synchronous word RAM with byte write enables and registered read data.
module dbus_sram_bank #(
    parameter int unsigned Depth = 4096,
    parameter int unsigned AddrW = 12
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic [3:0]       i_be,
    input  logic [AddrW-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [Depth];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (|i_be) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_dmem_resp.sv
// dbus responder backed by a byte-writable scratchpad: loads return the aligned word,
// stores are lane-steered here. Range/alignment errors are acked with addr_err.
module dbus_dmem_resp
    import dbus_dmem_resp_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES     = 1
) (
    input logic             clk,
    input logic             rst,
    dbus_dmem_resp_if.slave dbus
);

    localparam int unsigned AddrW    = $clog2(MEM_DEPTH_WORDS);
    localparam logic [31:0] MemBytes = 32'(4 * MEM_DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    type_dbus_resp_state_e r_state;
    type_dbus_resp_state_e w_state_next;

    logic [3:0]       r_cnt;
    logic [AddrW-1:0] r_word_idx;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_wdata;
    type_st_ops_e     r_st_ops;
    logic             r_is_store;
    logic             r_err;

    logic             w_req;
    logic [31:0]      w_offset;
    logic             w_in_range;
    logic             w_misaligned;
    type_st_lane_s    w_lane;
    logic [3:0]       w_sram_be;
    logic [AddrW-1:0] w_sram_addr;
    logic             w_sram_en;
    logic [31:0]      w_sram_rdata;
    logic             w_resp_live;

    assign w_req        = dbus.lsu2dbus.ld_req | dbus.lsu2dbus.st_req;
    assign w_offset     = dbus.lsu2dbus.addr - BASE_ADDR;
    assign w_in_range   = w_offset < MemBytes;
    assign w_misaligned = dbus.lsu2dbus.st_req
                          & st_misaligned(dbus.lsu2dbus.st_ops, dbus.lsu2dbus.addr[1:0]);
    assign w_resp_live  = (r_state == StResp) & w_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_state_next = (WAIT_CYCLES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (!w_req) begin
                    w_state_next = StIdle;
                end else if (r_cnt <= 4'd1) begin
                    w_state_next = StResp;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Only the word index and byte offset of the address are ever needed after sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_word_idx <= '0;
            r_addr_lo  <= 2'd0;
            r_wdata    <= 32'h0;
            r_st_ops   <= StOpSb;
            r_is_store <= 1'b0;
            r_err      <= 1'b0;
        end else if (r_state == StIdle) begin
            if (w_req) begin
                r_cnt      <= WaitInit;
                r_word_idx <= w_offset[AddrW+1:2];
                r_addr_lo  <= dbus.lsu2dbus.addr[1:0];
                r_wdata    <= dbus.lsu2dbus.w_data;
                r_st_ops   <= dbus.lsu2dbus.st_ops;
                r_is_store <= dbus.lsu2dbus.st_req;
                r_err      <= ~w_in_range | w_misaligned;
            end
        end else if (r_state == StWait && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign w_lane      = build_st_lane(r_st_ops, r_addr_lo, r_wdata);
    assign w_sram_be   = (w_resp_live && r_is_store && !r_err) ? w_lane.be : 4'b0000;
    assign w_sram_addr = (r_state == StIdle) ? w_offset[AddrW+1:2] : r_word_idx;
    // Read lands in the RAM output register on the edge that enters RESP.
    assign w_sram_en   = (|w_sram_be) | (w_state_next == StResp);

    dbus_sram_bank #(
        .Depth (MEM_DEPTH_WORDS),
        .AddrW (AddrW)
    ) u_sram_bank (
        .i_clk   (clk),
        .i_en    (w_sram_en),
        .i_be    (w_sram_be),
        .i_addr  (w_sram_addr),
        .i_wdata (w_lane.data),
        .o_rdata (w_sram_rdata)
    );

    always_comb begin
        dbus.dbus2lsu = '0;
        dbus.addr_err = 1'b0;
        if (w_resp_live) begin
            dbus.dbus2lsu.ack = 1'b1;
            dbus.addr_err     = r_err;
            if (!r_is_store && !r_err) begin
                dbus.dbus2lsu.r_data = w_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dbus_dmem_resp.sv
// Directed bench for dbus_dmem_resp at WAIT_CYCLES = 0, 1 and 3.
module tb_dbus_dmem_resp;
    import dbus_dmem_resp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;
    int unsigned last_ack_cyc = 0;

    type_lsu2dbus_s r_req   [3];
    logic           w_ack   [3];
    logic [31:0]    w_rdata [3];
    logic           w_aerr  [3];

    dbus_dmem_resp_if u_if0 ();
    dbus_dmem_resp_if u_if1 ();
    dbus_dmem_resp_if u_if3 ();

    assign u_if0.lsu2dbus = r_req[0];
    assign u_if1.lsu2dbus = r_req[1];
    assign u_if3.lsu2dbus = r_req[2];
    assign w_ack[0]   = u_if0.dbus2lsu.ack;
    assign w_ack[1]   = u_if1.dbus2lsu.ack;
    assign w_ack[2]   = u_if3.dbus2lsu.ack;
    assign w_rdata[0] = u_if0.dbus2lsu.r_data;
    assign w_rdata[1] = u_if1.dbus2lsu.r_data;
    assign w_rdata[2] = u_if3.dbus2lsu.r_data;
    assign w_aerr[0]  = u_if0.addr_err;
    assign w_aerr[1]  = u_if1.addr_err;
    assign w_aerr[2]  = u_if3.addr_err;

    dbus_dmem_resp #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .dbus(u_if0));
    dbus_dmem_resp #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .dbus(u_if1));
    dbus_dmem_resp #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .dbus(u_if3));

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int d, input string tag);
        check({tag, " ack"}, {31'b0, w_ack[d]}, 32'h0);
        check({tag, " rdata"}, w_rdata[d], 32'h0);
        check({tag, " err"}, {31'b0, w_aerr[d]}, 32'h0);
    endtask

    // Drives one request, waits (bounded) for ack, checks latency/data/error, then releases.
    task automatic access(input int d, input logic ld, input logic st, input type_st_ops_e op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat = 0;
        string t;
        t = $sformatf("d%0d %s %h", d, st ? "st" : "ld", addr);
        r_req[d] = '{addr: addr, w_data: wdata, ld_req: ld, st_req: st, st_ops: op};
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (w_ack[d] !== 1'b1 && lat < 20);
        last_ack_cyc = cyc;
        check({t, " latency"}, 32'(lat), 32'(1 + wait_of(d)));
        check({t, " rdata"}, w_rdata[d], exp_rdata);
        check({t, " err"}, {31'b0, w_aerr[d]}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        r_req[d] = '0;
    endtask

    task automatic st(input int d, input type_st_ops_e op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err);
        access(d, 1'b0, 1'b1, op, addr, wdata, 32'h0, exp_err);
    endtask

    task automatic ld(input int d, input logic [31:0] addr, input logic [31:0] exp_rdata,
                      input logic exp_err);
        access(d, 1'b1, 1'b0, StOpSw, addr, 32'h0, exp_rdata, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned c1, c2, c3;
        for (int i = 0; i < 3; i++) r_req[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet(0, "reset d0");
        check_quiet(1, "reset d1");
        check_quiet(2, "reset d3");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // WAIT_CYCLES = 1: basic word store/load
        st(1, StOpSw, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        ld(1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        check_quiet(1, "post-ack idle");
        @(posedge clk);
        #1;

        // byte and halfword lane steering
        st(1, StOpSw, 32'h8000_0010, 32'h1122_3344, 1'b0);
        st(1, StOpSb, 32'h8000_0013, 32'h0000_00A5, 1'b0);
        ld(1, 32'h8000_0010, 32'hA522_3344, 1'b0);
        st(1, StOpSh, 32'h8000_0012, 32'h0000_BEEF, 1'b0);
        ld(1, 32'h8000_0010, 32'hBEEF_3344, 1'b0);
        st(1, StOpSh, 32'h8000_0010, 32'h1234_5678, 1'b0);
        st(1, StOpSb, 32'h8000_0011, 32'h0000_00C3, 1'b0);
        ld(1, 32'h8000_0010, 32'hBEEF_C378, 1'b0);

        // error cases leave memory untouched; misaligned loads are not errors
        st(1, StOpSw, 32'h8000_0000, 32'hCAFE_F00D, 1'b0);
        ld(1, 32'h7FFF_FFFC, 32'h0, 1'b1);
        st(1, StOpSh, 32'h8000_0001, 32'h0000_FFFF, 1'b1);
        st(1, StOpSw, 32'h8000_0002, 32'hFFFF_FFFF, 1'b1);
        ld(1, 32'h8000_0001, 32'hCAFE_F00D, 1'b0);

        // top of the range vs first address past it (aliases word 0 if decode is wrong)
        st(1, StOpSw, 32'h8000_3FFC, 32'h0BAD_CAFE, 1'b0);
        st(1, StOpSw, 32'h8000_4000, 32'h5555_5555, 1'b1);
        ld(1, 32'h8000_3FFC, 32'h0BAD_CAFE, 1'b0);
        ld(1, 32'h8000_0000, 32'hCAFE_F00D, 1'b0);
        ld(1, 32'h8000_4000, 32'h0, 1'b1);

        // ld_req and st_req together behave as a store
        access(1, 1'b1, 1'b1, StOpSw, 32'h8000_0020, 32'h600D_F00D, 32'h0, 1'b0);
        ld(1, 32'h8000_0020, 32'h600D_F00D, 1'b0);

        // WAIT_CYCLES = 3: abort by dropping req after two cycles
        st(2, StOpSw, 32'h8000_0040, 32'h1357_9BDF, 1'b0);
        r_req[2] = '{addr: 32'h8000_0040, w_data: 32'hFFFF_FFFF, ld_req: 1'b0,
                     st_req: 1'b1, st_ops: StOpSw};
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("abort pre-drop ack", {31'b0, w_ack[2]}, 32'h0);
        end
        r_req[2] = '0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check("abort post-drop ack", {31'b0, w_ack[2]}, 32'h0);
        end
        @(posedge clk);
        #1;
        ld(2, 32'h8000_0040, 32'h1357_9BDF, 1'b0);

        // reset pulsed during WAIT of a store
        r_req[2] = '{addr: 32'h8000_0040, w_data: 32'h0, ld_req: 1'b0,
                     st_req: 1'b1, st_ops: StOpSw};
        @(posedge clk);
        @(negedge clk);
        check("rst pre ack", {31'b0, w_ack[2]}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet(2, "rst in wait");
        rst = 1'b0;
        r_req[2] = '0;
        @(posedge clk);
        @(negedge clk);
        check_quiet(2, "after rst");
        @(posedge clk);
        #1;
        ld(2, 32'h8000_0040, 32'h1357_9BDF, 1'b0);

        // WAIT_CYCLES = 0: back-to-back LW, SW, LW
        st(0, StOpSw, 32'h8000_0050, 32'hA1B2_C3D4, 1'b0);
        ld(0, 32'h8000_0050, 32'hA1B2_C3D4, 1'b0);
        c1 = last_ack_cyc;
        st(0, StOpSw, 32'h8000_0054, 32'h0F1E_2D3C, 1'b0);
        c2 = last_ack_cyc;
        ld(0, 32'h8000_0054, 32'h0F1E_2D3C, 1'b0);
        c3 = last_ack_cyc;
        check("b2b gap 1", c2 - c1, 32'd2);
        check("b2b gap 2", c3 - c2, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
